// File: rtl/vx_mem_rsp_reorder.sv
// vx_mem_rsp_reorder
//
// Restores request order for read responses coming back from the AXI memory
// adapter. Each core read is given a slot in a circular reorder buffer, and the
// slot index is sent to the adapter as the memory tag. Responses may return in
// any order. They are parked in their slots and released to the core strictly
// in allocation order, with the original core tag restored. Writes pass
// straight through and are not tracked.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   core_req_*          core request channel (valid/ready, rw, byteen, addr,
//                       data, tag)
//   core_rsp_*          in-order read responses to the core (valid/ready,
//                       data, tag)
//   mem_req_*           request channel to the adapter; tag = slot index for
//                       reads, 0 for writes
//   mem_rsp_*           read responses from the adapter, tagged by slot index;
//                       mem_rsp_ready is always 1
`timescale 1ns/1ps

module vx_mem_rsp_reorder #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 16,
  parameter int SIZE       = 16,
  localparam int SLOTW     = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    core_req_valid,
  output logic                    core_req_ready,
  input  logic                    core_req_rw,
  input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_data,
  input  logic [TAG_WIDTH-1:0]    core_req_tag,

  output logic                    core_rsp_valid,
  input  logic                    core_rsp_ready,
  output logic [DATA_WIDTH-1:0]   core_rsp_data,
  output logic [TAG_WIDTH-1:0]    core_rsp_tag,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_rw,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [SLOTW-1:0]        mem_req_tag,

  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [SLOTW-1:0]        mem_rsp_tag
);

  localparam int               CNTW     = $clog2(SIZE + 1);
  localparam logic [CNTW-1:0]  FULL_CNT = CNTW'(SIZE);

  // Occupancy and ring pointers. SIZE is a power of two, so the pointers wrap
  // from SIZE-1 to 0 by plain overflow.
  logic [SLOTW-1:0] alloc_ptr;
  logic [SLOTW-1:0] retire_ptr;
  logic [CNTW-1:0]  count;
  logic [SIZE-1:0]  done;

  // Per-slot payload: core tag written at allocation, data written on fill.
  logic [TAG_WIDTH-1:0]  tag_mem  [SIZE];
  logic [DATA_WIDTH-1:0] data_mem [SIZE];

  logic            full;
  logic            req_ok;
  logic            alloc_fire;
  logic            fill_fire;
  logic            retire_fire;
  logic [SIZE-1:0] fill_mask;
  logic [SIZE-1:0] retire_mask;

  // ---------------------------------------------------------------------------
  // Request path: combinational pass-through, reads gated by buffer space.
  // ---------------------------------------------------------------------------
  // Gating uses the registered count only, so a retire in the same cycle does
  // not unblock a read until the next cycle. This keeps ready free of any path
  // from core_rsp_ready.
  assign full   = (count == FULL_CNT);
  assign req_ok = core_req_rw || !full;

  assign mem_req_valid  = core_req_valid && req_ok;
  assign core_req_ready = mem_req_ready && req_ok;

  assign mem_req_rw     = core_req_rw;
  assign mem_req_byteen = core_req_byteen;
  assign mem_req_addr   = core_req_addr;
  assign mem_req_data   = core_req_data;
  assign mem_req_tag    = core_req_rw ? '0 : alloc_ptr;

  assign alloc_fire = core_req_valid && core_req_ready && !core_req_rw;

  // ---------------------------------------------------------------------------
  // Response path.
  // ---------------------------------------------------------------------------
  // Every outstanding read already owns a slot, so fills are never refused.
  assign mem_rsp_ready = 1'b1;
  assign fill_fire     = mem_rsp_valid;

  assign core_rsp_valid = done[retire_ptr];
  assign core_rsp_data  = data_mem[retire_ptr];
  assign core_rsp_tag   = tag_mem[retire_ptr];

  assign retire_fire = core_rsp_valid && core_rsp_ready;

  assign fill_mask   = fill_fire   ? (SIZE'(1) << mem_rsp_tag) : '0;
  assign retire_mask = retire_fire ? (SIZE'(1) << retire_ptr)  : '0;

  // ---------------------------------------------------------------------------
  // Control state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      count      <= '0;
      done       <= '0;   // fills arriving while in reset are dropped here
    end else begin
      if (alloc_fire) begin
        alloc_ptr <= alloc_ptr + SLOTW'(1);
      end
      if (retire_fire) begin
        retire_ptr <= retire_ptr + SLOTW'(1);
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;   // idle, or alloc and retire together
      endcase
      // A retiring slot is already done, so it can never be the fill target
      // in the same cycle; clear-then-set order is therefore immaterial.
      done <= (done & ~retire_mask) | fill_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot payload storage.
  // ---------------------------------------------------------------------------
  // NOTE: the payload arrays carry no reset. A slot is only ever read while
  // its done bit is set, and done bits are cleared by reset, so stale contents
  // are never observed. Leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      tag_mem[alloc_ptr] <= core_req_tag;
    end
    if (fill_fire) begin
      data_mem[mem_rsp_tag] <= mem_rsp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks on the adapter side.
  // ---------------------------------------------------------------------------
  // Distance of the fill slot from the head; it must fall inside the window of
  // outstanding reads [retire_ptr, alloc_ptr).
  logic [SLOTW-1:0] fill_offset;
  assign fill_offset = mem_rsp_tag - retire_ptr;

  a_fill_not_done : assert property (
    @(posedge clk) disable iff (!reset)
    fill_fire |-> !done[mem_rsp_tag]);

  a_fill_in_window : assert property (
    @(posedge clk) disable iff (!reset)
    fill_fire |-> (CNTW'(fill_offset) < count));

  a_fill_not_retiring : assert property (
    @(posedge clk) disable iff (!reset)
    !(fill_fire && retire_fire && (mem_rsp_tag == retire_ptr)));

endmodule

// File: tb/tb_vx_mem_rsp_reorder.sv
// tb_vx_mem_rsp_reorder
//
// Self-checking bench for vx_mem_rsp_reorder. The reference model is a plain
// FIFO of expected (tag, data) pairs in issue order plus a read counter whose
// value modulo SIZE is the slot the next read must receive. A monitor process
// pops the FIFO whenever the core response handshake completes.
`timescale 1ns/1ps

module tb_vx_mem_rsp_reorder;

  localparam int DW    = 512;
  localparam int AW    = 26;
  localparam int TW    = 16;
  localparam int SIZE  = 16;
  localparam int SLOTW = $clog2(SIZE);

  logic            clk;
  logic            reset;
  logic            core_req_valid;
  logic            core_req_ready;
  logic            core_req_rw;
  logic [DW/8-1:0] core_req_byteen;
  logic [AW-1:0]   core_req_addr;
  logic [DW-1:0]   core_req_data;
  logic [TW-1:0]   core_req_tag;
  logic            core_rsp_valid;
  logic            core_rsp_ready;
  logic [DW-1:0]   core_rsp_data;
  logic [TW-1:0]   core_rsp_tag;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [SLOTW-1:0] mem_req_tag;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic [DW-1:0]   mem_rsp_data;
  logic [SLOTW-1:0] mem_rsp_tag;

  vx_mem_rsp_reorder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAG_WIDTH  (TW),
    .SIZE       (SIZE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_rw     (core_req_rw),
    .core_req_byteen (core_req_byteen),
    .core_req_addr   (core_req_addr),
    .core_req_data   (core_req_data),
    .core_req_tag    (core_req_tag),
    .core_rsp_valid  (core_rsp_valid),
    .core_rsp_ready  (core_rsp_ready),
    .core_rsp_data   (core_rsp_data),
    .core_rsp_tag    (core_rsp_tag),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_rw      (mem_req_rw),
    .mem_req_byteen  (mem_req_byteen),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_tag     (mem_req_tag),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_ready   (mem_rsp_ready),
    .mem_rsp_data    (mem_rsp_data),
    .mem_rsp_tag     (mem_rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model and bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];          // expected core responses, issue order
  logic [DW-1:0] slot_data [SIZE];  // data the adapter returns for each slot
  int            pending[$];        // issued reads not yet returned by adapter
  int            alloc_cnt;         // reads accepted since reset
  int            retired_cnt;       // responses taken by the core since reset
  int            n_checks;
  int            n_pass;

  function automatic int outstanding();
    return alloc_cnt - retired_cnt;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic remove_pending(input int slot);
    int idx;
    idx = -1;
    for (int i = 0; i < pending.size(); i++)
      if (pending[i] == slot && idx < 0) idx = i;
    if (idx >= 0) pending.delete(idx);
  endtask

  // Monitor: every completed core response must match the oldest expectation.
  rsp_t mon_e;
  always @(negedge clk) begin
    if (reset && core_rsp_valid && core_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: tag %0h arrived with nothing outstanding",
                 core_rsp_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_tag", core_rsp_tag, mon_e.tag);
        check("rsp_data", core_rsp_data, mon_e.data);
        retired_cnt++;
      end
    end
  end

  // One read request; the model decides slot and return data.
  task automatic issue_read(input logic [TW-1:0] tag, input logic [AW-1:0] addr);
    logic [DW-1:0] d;
    rsp_t e;
    int slot;
    d    = rand_data();
    slot = alloc_cnt % SIZE;
    core_req_valid  = 1'b1;
    core_req_rw     = 1'b0;
    core_req_tag    = tag;
    core_req_addr   = addr;
    core_req_data   = rand_data();
    core_req_byteen = {$urandom, $urandom};
    @(negedge clk);
    check("rd_ready", core_req_ready, 1);
    check("rd_mem_valid", mem_req_valid, 1);
    check("rd_mem_tag", mem_req_tag, slot);
    check("rd_addr", mem_req_addr, addr);
    if (core_req_ready) begin
      slot_data[slot] = d;
      e.tag  = tag;
      e.data = d;
      exp_q.push_back(e);
      pending.push_back(slot);
      alloc_cnt++;
    end
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
  endtask

  // Adapter returns one slot. exp_valid >= 0 also checks core_rsp_valid in
  // the cycle the response is presented.
  task automatic mem_return(input int slot, input int exp_valid);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = SLOTW'(slot);
    mem_rsp_data  = slot_data[slot];
    remove_pending(slot);
    if (exp_valid >= 0) begin
      @(negedge clk);
      check("rsp_before_head", core_rsp_valid, exp_valid);
    end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 8 * SIZE && outstanding() != 0; i++) tick();
    check(name, outstanding(), 0);
  endtask

  task automatic drain_all(input string name);
    int k;
    core_rsp_ready = 1'b1;
    while (pending.size() > 0) begin
      k = $urandom_range(0, pending.size() - 1);
      mem_return(pending[k], -1);
    end
    wait_drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int            base;
  int            head;
  int            slot;
  int            idx;
  bit            do_req;
  bit            rw;
  bit            can;
  logic [DW-1:0] d;
  logic [DW-1:0] wd;
  logic [AW-1:0] addr;
  rsp_t          e;

  initial begin
    n_checks = 0; n_pass = 0; alloc_cnt = 0; retired_cnt = 0;
    reset = 1'b0;
    core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_byteen = '0;
    core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
    core_rsp_ready = 1'b1; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_rsp_valid", core_rsp_valid, 0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 1);
    check("rst_req_ready", core_req_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    tick();

    // Single read: response visible one cycle after the fill.
    issue_read(16'hABCD, 26'h100);
    mem_return(0, 0);
    @(negedge clk);
    check("single_latency", core_rsp_valid, 1);
    check("single_tag", core_rsp_tag, 16'hABCD);
    tick();
    wait_drain("single_drain");

    // Reversed return: nothing leaves until the head fills, then 4 in a row.
    base = alloc_cnt % SIZE;
    for (int i = 0; i < 4; i++) issue_read(TW'(10 + i), AW'($urandom));
    for (int k = 3; k >= 0; k--) mem_return((base + k) % SIZE, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rev_valid", core_rsp_valid, 1);
      check("rev_tag", core_rsp_tag, TW'(10 + i));
      tick();
    end
    @(negedge clk);
    check("rev_after", core_rsp_valid, 0);
    tick();
    wait_drain("rev_drain");

    // Full: SIZE reads outstanding, reads stall, writes flow.
    for (int i = 0; i < SIZE; i++) issue_read(TW'(16'h200 + i), AW'($urandom));
    core_req_valid = 1'b1; core_req_rw = 1'b0; core_req_tag = 16'h3000;
    @(negedge clk);
    check("full_rd_ready", core_req_ready, 0);
    check("full_rd_valid", mem_req_valid, 0);
    tick();
    wd = rand_data();
    addr = AW'($urandom);
    core_req_rw = 1'b1; core_req_data = wd; core_req_addr = addr;
    @(negedge clk);
    check("full_wr_ready", core_req_ready, 1);
    check("full_wr_valid", mem_req_valid, 1);
    check("full_wr_tag", mem_req_tag, 0);
    check("full_wr_rw", mem_req_rw, 1);
    check("full_wr_data", mem_req_data, wd);
    check("full_wr_addr", mem_req_addr, addr);
    tick();
    head = retired_cnt % SIZE;
    core_req_rw = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_tag = SLOTW'(head); mem_rsp_data = slot_data[head];
    remove_pending(head);
    @(negedge clk);
    check("full_fill_ready", core_req_ready, 0);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("full_retire_valid", core_rsp_valid, 1);
    check("full_same_cycle", core_req_ready, 0);
    tick();
    issue_read(16'h3000, AW'($urandom));   // accepted the cycle after retire
    drain_all("full_drain");

    // Wrap-around: 3*SIZE reads, each returned at once.
    for (int i = 0; i < 3 * SIZE; i++) begin
      issue_read(TW'($urandom), AW'($urandom));
      mem_return((alloc_cnt - 1) % SIZE, -1);
    end
    wait_drain("wrap_drain");

    // Backpressure: 5 completed slots held for 20 cycles, then released.
    core_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue_read(TW'($urandom), AW'($urandom));
    while (pending.size() > 0) begin
      idx = $urandom_range(0, pending.size() - 1);
      mem_return(pending[idx], -1);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_valid", core_rsp_valid, 1);
      check("bp_tag", core_rsp_tag, exp_q[0].tag);
      check("bp_data", core_rsp_data, exp_q[0].data);
      tick();
    end
    core_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_release", core_rsp_valid, 1);
      tick();
    end
    @(negedge clk);
    check("bp_empty", core_rsp_valid, 0);
    tick();
    wait_drain("bp_drain");

    // Reset mid-flight with 6 outstanding reads, two of them already filled.
    base = alloc_cnt % SIZE;
    for (int i = 0; i < 6; i++) issue_read(TW'($urandom), AW'($urandom));
    mem_return((base + 2) % SIZE, 0);
    mem_return((base + 4) % SIZE, 0);
    reset = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_tag = SLOTW'(base); mem_rsp_data = slot_data[base];
    tick();
    reset = 1'b1;
    mem_rsp_valid = 1'b0;
    exp_q.delete(); pending.delete(); alloc_cnt = 0; retired_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_mid_valid", core_rsp_valid, 0);
      tick();
    end
    issue_read(16'h5A5A, AW'($urandom));   // must get slot 0
    for (int i = 1; i < SIZE; i++) issue_read(TW'($urandom), AW'($urandom));
    core_req_valid = 1'b1; core_req_rw = 1'b0;
    @(negedge clk);
    check("rst_count_full", core_req_ready, 0);
    tick();
    core_req_valid = 1'b0;
    drain_all("rst_drain");

    // Randomised traffic: mixed reads/writes, random fills and backpressure.
    for (int c = 0; c < 400; c++) begin
      do_req = 1'($urandom_range(0, 1));
      rw     = ($urandom_range(0, 3) == 0);
      d      = rand_data();
      wd     = rand_data();
      addr   = AW'($urandom);
      mem_req_ready   = ($urandom_range(0, 3) != 0);
      core_rsp_ready  = ($urandom_range(0, 3) != 0);
      core_req_valid  = do_req;
      core_req_rw     = rw;
      core_req_tag    = TW'($urandom);
      core_req_addr   = addr;
      core_req_data   = wd;
      core_req_byteen = {$urandom, $urandom};
      can = rw || (outstanding() < SIZE);
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx  = $urandom_range(0, pending.size() - 1);
        slot = pending[idx];
        pending.delete(idx);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = SLOTW'(slot);
        mem_rsp_data  = slot_data[slot];
      end else begin
        mem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      if (do_req) begin
        check("rnd_ready", core_req_ready, mem_req_ready && can);
        check("rnd_mem_valid", mem_req_valid, can);
        check("rnd_addr", mem_req_addr, addr);
        if (mem_req_ready && can) begin
          if (rw) begin
            check("rnd_wr_tag", mem_req_tag, 0);
            check("rnd_wr_data", mem_req_data, wd);
          end else begin
            check("rnd_rd_tag", mem_req_tag, alloc_cnt % SIZE);
            slot_data[alloc_cnt % SIZE] = d;
            e.tag  = core_req_tag;
            e.data = d;
            exp_q.push_back(e);
            pending.push_back(alloc_cnt % SIZE);
            alloc_cnt++;
          end
        end
      end
      tick();
    end
    core_req_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_req_ready  = 1'b1;
    drain_all("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
